// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap_pkg
//  Description : Shared definitions for the 8-bit computer's program-mode
//                blocks: bus/RAM widths, RAM depth, the readback FSM state
//                encoding (so the control unit and benches can decode it)
//                and a small width helper for down-counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETADDR = 3'd1;
    localparam logic [STATE_W-1:0] ST_READ    = 3'd2;
    localparam logic [STATE_W-1:0] ST_EMIT    = 3'd3;
    localparam logic [STATE_W-1:0] ST_FINISH  = 3'd4;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : sap_pkg
`default_nettype wire

// File: rtl/settle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : settle_counter
//  Description : Loadable down-counter with terminal-count flag. Counts down
//                while enabled and parks at zero; tc is high at zero.
//  Ports       : clk, rst (sync, active-high), load/load_val (preset),
//                en (count enable), tc (count is zero)
//  Revision    : 1.0 - initial release
// ============================================================================
module settle_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && !tc) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign tc = (r_cnt == '0);

endmodule : settle_counter
`default_nettype wire

// File: rtl/ram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_dump_reader
//  Description : Program-mode readback engine for the 16x8 RAM. Takes the bus
//                with pmode, loads MAR with each address FIRST..LAST, enables
//                the RAM onto the bus for SETTLE cycles, captures the byte,
//                streams it out on a valid/ready port and keeps a mod-2^DATA_W
//                running checksum.
//  Ports       : clk, clr (sync, active-high), start,
//                pmode, mar_addr, mar_load, ramoa, bus_in   (board side)
//                dout, dout_valid, dout_ready               (stream side)
//                busy, done, checksum                       (status)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_dump_reader
    import sap_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FIRST  = 0,
    parameter int LAST   = 15,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    output logic              pmode,
    output logic [ADDR_W-1:0] mar_addr,
    output logic              mar_load,
    output logic              ramoa,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam int                CNT_W        = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0]  C_SETTLE_LD  = CNT_W'(SETTLE - 1);
    localparam logic [ADDR_W-1:0] C_FIRST      = ADDR_W'(FIRST);
    localparam logic [ADDR_W-1:0] C_LAST       = ADDR_W'(LAST);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_dout;
    logic [DATA_W-1:0]  r_csum;
    logic               w_settle_tc;
    logic               w_handshake;
    logic               w_at_last;

    assign w_handshake = (r_state == ST_EMIT) && dout_ready;
    // Compared before the increment so LAST = 2^ADDR_W-1 cannot wrap to 0.
    assign w_at_last   = (r_addr == C_LAST);

    // Loaded with SETTLE-1 during SETADDR; tc marks the final READ cycle.
    settle_counter #(
        .W (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (clr),
        .load     (r_state == ST_SETADDR),
        .load_val (C_SETTLE_LD),
        .en       (r_state == ST_READ),
        .tc       (w_settle_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_SETADDR;
            ST_SETADDR: w_next = ST_READ;
            ST_READ:    if (w_settle_tc) w_next = ST_EMIT;
            ST_EMIT:    if (dout_ready) w_next = w_at_last ? ST_FINISH : ST_SETADDR;
            ST_FINISH:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Datapath: address counter, captured byte, running checksum.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_addr <= '0;
            r_dout <= '0;
            r_csum <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_addr <= C_FIRST;
                r_csum <= '0;
            end
            if ((r_state == ST_READ) && w_settle_tc) begin
                r_dout <= bus_in;
                r_csum <= r_csum + bus_in;
            end
            if (w_handshake && !w_at_last) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Output decode. pmode covers every non-IDLE state so it never drops
    // between bytes; ramoa and mar_load live in disjoint states.
    always_comb begin
        pmode      = 1'b0;
        mar_addr   = '0;
        mar_load   = 1'b0;
        ramoa      = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            ST_SETADDR: begin
                pmode    = 1'b1;
                busy     = 1'b1;
                mar_addr = r_addr;
                mar_load = 1'b1;
            end
            ST_READ: begin
                pmode    = 1'b1;
                busy     = 1'b1;
                mar_addr = r_addr;
                ramoa    = 1'b1;
            end
            ST_EMIT: begin
                pmode      = 1'b1;
                busy       = 1'b1;
                mar_addr   = r_addr;
                dout_valid = 1'b1;
            end
            ST_FINISH: begin
                pmode = 1'b1;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    assign dout     = r_dout;
    assign checksum = r_csum;

endmodule : ram_dump_reader
`default_nettype wire

// File: tb/tb_ram_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_dump_reader
//  Description : Self-checking bench for ram_dump_reader. Three instances:
//                u_dut0 (defaults), u_dut1 (FIRST=LAST=14), u_dut2 (SETTLE=3).
//                A RAM/MAR model drives each bus; expected bytes are queued
//                at start and popped on every handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_dump_reader;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] ram [16];

    logic       start0, start1, start2;
    logic       ready0, ready1, ready2;
    logic       pmode0, pmode1, pmode2;
    logic [3:0] maddr0, maddr1, maddr2;
    logic       mload0, mload1, mload2;
    logic       ramoa0, ramoa1, ramoa2;
    logic [7:0] bus0, bus1, bus2;
    logic [7:0] dout0, dout1, dout2;
    logic       valid0, valid1, valid2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic [7:0] csum0, csum1, csum2;

    logic [3:0] mar0, mar1, mar2;
    int         oe_cnt2;
    int         oe_run2;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    int         pops0, dones0, dones1, dones2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_dump_reader u_dut0 (
        .clk(clk), .clr(clr), .start(start0), .pmode(pmode0), .mar_addr(maddr0),
        .mar_load(mload0), .ramoa(ramoa0), .bus_in(bus0), .dout(dout0),
        .dout_valid(valid0), .dout_ready(ready0), .busy(busy0), .done(done0),
        .checksum(csum0));

    ram_dump_reader #(.FIRST(14), .LAST(14)) u_dut1 (
        .clk(clk), .clr(clr), .start(start1), .pmode(pmode1), .mar_addr(maddr1),
        .mar_load(mload1), .ramoa(ramoa1), .bus_in(bus1), .dout(dout1),
        .dout_valid(valid1), .dout_ready(ready1), .busy(busy1), .done(done1),
        .checksum(csum1));

    ram_dump_reader #(.SETTLE(3)) u_dut2 (
        .clk(clk), .clr(clr), .start(start2), .pmode(pmode2), .mar_addr(maddr2),
        .mar_load(mload2), .ramoa(ramoa2), .bus_in(bus2), .dout(dout2),
        .dout_valid(valid2), .dout_ready(ready2), .busy(busy2), .done(done2),
        .checksum(csum2));

    // MAR registers and RAM read model. Off-bus value is a marker so a
    // sample taken at the wrong time shows up as a wrong byte.
    always @(posedge clk) begin
        if (mload0) mar0 <= maddr0;
        if (mload1) mar1 <= maddr1;
        if (mload2) mar2 <= maddr2;
        oe_cnt2 <= ramoa2 ? oe_cnt2 + 1 : 0;
    end
    assign bus0 = ramoa0 ? ram[mar0] : 8'hA5;
    assign bus1 = ramoa1 ? ram[mar1] : 8'hA5;
    // The slow RAM only presents valid data on its third enabled cycle.
    assign bus2 = (ramoa2 && oe_cnt2 == 2) ? ram[mar2] : 8'h5A;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop + bus-protocol checks, sampled on the falling edge.
    always @(negedge clk) begin
        check("oe_and_load0", 32'(ramoa0 & mload0), 32'(0));
        check("oe_wo_pmode0", 32'(ramoa0 & ~pmode0), 32'(0));
        check("oe_and_load1", 32'(ramoa1 & mload1), 32'(0));
        check("oe_wo_pmode1", 32'(ramoa1 & ~pmode1), 32'(0));
        check("oe_and_load2", 32'(ramoa2 & mload2), 32'(0));
        check("oe_wo_pmode2", 32'(ramoa2 & ~pmode2), 32'(0));
        if (valid0 && ready0 && !clr) begin
            check("byte0_expected", 32'(q0.size() != 0), 32'(1));
            if (q0.size() != 0) check("byte0", 32'(dout0), 32'(q0.pop_front()));
            pops0++;
        end
        if (valid1 && ready1) begin
            check("byte1_expected", 32'(q1.size() != 0), 32'(1));
            if (q1.size() != 0) check("byte1", 32'(dout1), 32'(q1.pop_front()));
        end
        if (valid2 && ready2) begin
            check("byte2_expected", 32'(q2.size() != 0), 32'(1));
            if (q2.size() != 0) check("byte2", 32'(dout2), 32'(q2.pop_front()));
        end
        if (ramoa2) begin
            oe_run2++;
        end else if (oe_run2 != 0) begin
            check("oe_run2", 32'(oe_run2), 32'(3));
            oe_run2 = 0;
        end
        if (done0) dones0++;
        if (done1) dones1++;
        if (done2) dones2++;
    end

    task automatic chk_idle0(input string tag);
        check({tag, "_pmode"},    32'(pmode0), 32'(0));
        check({tag, "_busy"},     32'(busy0),  32'(0));
        check({tag, "_done"},     32'(done0),  32'(0));
        check({tag, "_valid"},    32'(valid0), 32'(0));
        check({tag, "_ramoa"},    32'(ramoa0), 32'(0));
        check({tag, "_marload"},  32'(mload0), 32'(0));
        check({tag, "_maraddr"},  32'(maddr0), 32'(0));
        check({tag, "_dout"},     32'(dout0),  32'(0));
        check({tag, "_checksum"}, 32'(csum0),  32'(0));
    endtask

    // One dump on u_dut0. Called #1 after a rising edge. stall_byte: index of
    // the byte held off for 5 cycles (-1 none); abort_byte: index of the byte
    // during whose EMIT clr is asserted (-1 none); rnd: random start pulses.
    task automatic run0(input int stall_byte, input int abort_byte, input bit rnd,
                        output int t_first, output int t_done);
        int cyc   = 0;
        int stall = 0;
        int d0    = dones0;
        t_first = -1;
        t_done  = -1;
        pops0   = 0;
        for (int a = 0; a < 16; a++) q0.push_back(ram[a]);
        start0 = 1'b1;
        while (cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            start0 = (rnd && busy0 && !done0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (valid0 && t_first < 0) t_first = cyc;
            if (valid0 && pops0 == abort_byte) begin
                ready0 = 1'b0;
                clr    = 1'b1;
                @(posedge clk); #1;
                clr    = 1'b0;
                ready0 = 1'b1;
                chk_idle0("abort");
                q0.delete();
                return;
            end
            if (valid0 && pops0 == stall_byte && stall < 5) begin
                ready0 = 1'b0;
                stall++;
                check("stall_dout",  32'(dout0),  32'(ram[stall_byte]));
                check("stall_valid", 32'(valid0), 32'(1));
                check("stall_pmode", 32'(pmode0), 32'(1));
            end else begin
                ready0 = 1'b1;
            end
            if (!done0 && cyc > 1) check("pmode_held", 32'(pmode0), 32'(1));
            if (done0) begin
                t_done = cyc;
                break;
            end
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done0_pulses", 32'(dones0 - d0), 32'(1));
        check("q0_drained",   32'(q0.size()),   32'(0));
        check("pops0",        32'(pops0),       32'(16));
    endtask

    initial begin
        int tf, td, cyc;

        for (int a = 0; a < 16; a++) ram[a] = 8'h00;
        ram[0] = 8'h1E; ram[1] = 8'h2F; ram[2] = 8'hE0; ram[3] = 8'hF0;
        ram[14] = 8'h38; ram[15] = 8'h23;

        clr = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b1;
        mar0 = '0; mar1 = '0; mar2 = '0;
        oe_cnt2 = 0; oe_run2 = 0;
        pops0 = 0; dones0 = 0; dones1 = 0; dones2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle0("reset");
        clr = 1'b0;
        @(posedge clk); #1;

        // Full dump, ready tied high.
        run0(-1, -1, 1'b0, tf, td);
        check("t1_first_valid", 32'(tf),    32'(3));
        check("t1_done_cycle",  32'(td),    32'(49));
        check("t1_checksum",    32'(csum0), 32'h78);

        // Backpressure on byte 2 for 5 cycles.
        run0(2, -1, 1'b0, tf, td);
        check("t2_done_cycle", 32'(td),    32'(54));
        check("t2_checksum",   32'(csum0), 32'h78);

        // Reset during EMIT of byte 3, then a clean re-dump.
        run0(-1, 3, 1'b0, tf, td);
        @(posedge clk); #1;
        run0(-1, -1, 1'b0, tf, td);
        check("t3_first_valid", 32'(tf),    32'(3));
        check("t3_done_cycle",  32'(td),    32'(49));
        check("t3_checksum",    32'(csum0), 32'h78);

        // Random start pulses while busy are ignored.
        run0(-1, -1, 1'b1, tf, td);
        check("t5_done_cycle", 32'(td),    32'(49));
        check("t5_checksum",   32'(csum0), 32'h78);

        // Single-byte range.
        q1.push_back(ram[14]);
        start1 = 1'b1;
        cyc = 0; td = -1; tf = -1;
        while (cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            start1 = 1'b0;
            if (valid1 && tf < 0) tf = cyc;
            if (done1) begin td = cyc; break; end
        end
        repeat (3) @(posedge clk);
        #1;
        check("t4_first_valid", 32'(tf),         32'(3));
        check("t4_done_cycle",  32'(td),         32'(4));
        check("t4_checksum",    32'(csum1),      32'h38);
        check("t4_done_pulses", 32'(dones1),     32'(1));
        check("t4_q_drained",   32'(q1.size()),  32'(0));

        // SETTLE=3: 5-cycle byte period, bus sampled on the 3rd ramoa cycle.
        for (int a = 0; a < 16; a++) q2.push_back(ram[a]);
        start2 = 1'b1;
        cyc = 0; td = -1; tf = -1;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start2 = 1'b0;
            if (valid2 && tf < 0) tf = cyc;
            if (done2) begin td = cyc; break; end
        end
        repeat (3) @(posedge clk);
        #1;
        check("t6_first_valid", 32'(tf),        32'(5));
        check("t6_done_cycle",  32'(td),        32'(81));
        check("t6_checksum",    32'(csum2),     32'h78);
        check("t6_done_pulses", 32'(dones2),    32'(1));
        check("t6_q_drained",   32'(q2.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ram_dump_reader
`default_nettype wire
